// File: rtl/sat_accumulator.sv
// Signed accumulator with overflow detection, wrap/saturate mode, sticky flag and event counter.
// Latency: one cycle from operand accept to registered result on acc_out/out_valid.
// Backpressure: in_ready drops while an unconsumed result is held (out_valid && !out_ready) or on clear.
module sat_accumulator #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] res_raw;
    logic [WIDTH-1:0] res;
    logic             acc_sgn;
    logic             opd_sgn;
    logic             res_sgn;
    logic             ovf_now;
    logic [WIDTH-1:0] max_v;
    logic [WIDTH-1:0] min_v;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !rst && !clear && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // Subtraction as acc + ~op + 1, evaluated one bit wider so bit WIDTH is the true sign.
    assign op_x    = in_sub ? ~in_operand : in_operand;
    assign sum_ext = {acc_out[WIDTH-1], acc_out} + {op_x[WIDTH-1], op_x}
                   + {{WIDTH{1'b0}}, in_sub};
    assign res_raw = sum_ext[WIDTH-1:0];

    assign acc_sgn = acc_out[WIDTH-1];
    assign opd_sgn = in_operand[WIDTH-1];
    assign res_sgn = res_raw[WIDTH-1];
    assign ovf_now = (in_sub ? (acc_sgn != opd_sgn) : (acc_sgn == opd_sgn))
                   && (res_sgn != acc_sgn);

    assign max_v = {1'b0, {(WIDTH-1){1'b1}}};
    assign min_v = {1'b1, {(WIDTH-1){1'b0}}};
    assign res   = (SATURATE && ovf_now) ? (sum_ext[WIDTH] ? min_v : max_v) : res_raw;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = HOLD;
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_out    <= '0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                acc_out    <= '0;
                ovf        <= 1'b0;
                ovf_sticky <= 1'b0;
                ovf_count  <= '0;
            end else if (accept) begin
                acc_out <= res;
                ovf     <= ovf_now;
                if (ovf_now) begin
                    ovf_sticky <= 1'b1;
                    if (ovf_count != {CNT_W{1'b1}}) begin
                        ovf_count <= ovf_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench: saturating and wrapping instances driven in lockstep.
// Table of single-op vectors plus hand sequences for reset, backpressure, counter and clear.
// Results are compared against hand-computed constants.
module tb_sat_accumulator;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_sub;
    logic [7:0] in_operand;
    logic       out_ready;

    logic       rdy_s, vld_s, ovf_s, stk_s;
    logic [7:0] acc_s;
    logic [1:0] cnt_s;
    logic       rdy_w, vld_w, ovf_w, stk_w;
    logic [7:0] acc_w;
    logic [1:0] cnt_w;

    int total = 0;
    int bad   = 0;

    sat_accumulator #(.WIDTH(8), .SATURATE(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy_s), .in_sub(in_sub), .in_operand(in_operand),
        .out_valid(vld_s), .out_ready(out_ready), .acc_out(acc_s),
        .ovf(ovf_s), .ovf_sticky(stk_s), .ovf_count(cnt_s)
    );

    sat_accumulator #(.WIDTH(8), .SATURATE(1'b0), .CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy_w), .in_sub(in_sub), .in_operand(in_operand),
        .out_valid(vld_w), .out_ready(out_ready), .acc_out(acc_w),
        .ovf(ovf_w), .ovf_sticky(stk_w), .ovf_count(cnt_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic       sub;
        logic [7:0] opd;
        logic [7:0] exp_sat;
        logic       ovf_sat;
        logic [7:0] exp_wrap;
        logic       ovf_wrap;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        in_valid   = 1'b1;
        in_sub     = 1'b0;
        in_operand = 8'd3;
        out_ready  = 1'b1;

        vec[0]  = '{1'b1, 1'b0, 8'd100, 8'd100, 1'b0, 8'd100, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 8'd50,  8'h7F,  1'b1, 8'h96,  1'b1};
        vec[2]  = '{1'b1, 1'b0, 8'h80,  8'h80,  1'b0, 8'h80,  1'b0};
        vec[3]  = '{1'b0, 1'b1, 8'h01,  8'h80,  1'b1, 8'h7F,  1'b1};
        vec[4]  = '{1'b1, 1'b1, 8'h80,  8'h7F,  1'b1, 8'h80,  1'b1};
        vec[5]  = '{1'b1, 1'b0, 8'h7F,  8'h7F,  1'b0, 8'h7F,  1'b0};
        vec[6]  = '{1'b0, 1'b1, 8'h7F,  8'h00,  1'b0, 8'h00,  1'b0};
        vec[7]  = '{1'b0, 1'b1, 8'h01,  8'hFF,  1'b0, 8'hFF,  1'b0};
        vec[8]  = '{1'b0, 1'b0, 8'h81,  8'h80,  1'b0, 8'h80,  1'b0};
        vec[9]  = '{1'b0, 1'b0, 8'hFF,  8'h80,  1'b1, 8'h7F,  1'b1};
        vec[10] = '{1'b1, 1'b0, 8'h40,  8'h40,  1'b0, 8'h40,  1'b0};
        vec[11] = '{1'b0, 1'b0, 8'h40,  8'h7F,  1'b1, 8'h80,  1'b1};
        vec[12] = '{1'b0, 1'b1, 8'h01,  8'h7E,  1'b0, 8'h7F,  1'b1};

        // Reset held two cycles with an operand offered
        step();
        chk("rst_in_ready", rdy_s, 0);
        step();
        chk("rst_acc", acc_s, 0);
        chk("rst_valid", vld_s, 0);
        chk("rst_ovf", ovf_s, 0);
        chk("rst_sticky", stk_s, 0);
        chk("rst_count", cnt_s, 0);
        chk("rst_in_ready2", rdy_s, 0);
        chk("rst_acc_w", acc_w, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            if (vec[i].clr) do_clear();
            in_valid   = 1'b1;
            in_sub     = vec[i].sub;
            in_operand = vec[i].opd;
            out_ready  = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), rdy_s, 1);
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_acc_sat", i), acc_s, vec[i].exp_sat);
            chk($sformatf("vec%0d_ovf_sat", i), ovf_s, vec[i].ovf_sat);
            chk($sformatf("vec%0d_acc_wrap", i), acc_w, vec[i].exp_wrap);
            chk($sformatf("vec%0d_ovf_wrap", i), ovf_w, vec[i].ovf_wrap);
            chk($sformatf("vec%0d_valid", i), vld_s, 1);
        end
        chk("post_tab_sticky_sat", stk_s, 1);
        chk("post_tab_count_sat", cnt_s, 1);
        chk("post_tab_sticky_wrap", stk_w, 1);
        chk("post_tab_count_wrap", cnt_w, 2);

        // Backpressure: result held, no further operand accepted
        do_clear();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_sub     = 1'b0;
        in_operand = 8'd5;
        #1;
        chk("bp_first_ready", rdy_s, 1);
        step();
        in_operand = 8'd7;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_stall%0d_ready", k), rdy_s, 0);
            chk($sformatf("bp_stall%0d_acc", k), acc_s, 5);
            chk($sformatf("bp_stall%0d_valid", k), vld_s, 1);
            step();
        end
        chk("bp_after_acc", acc_s, 5);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", rdy_s, 1);
        step();
        chk("bp_second_acc", acc_s, 12);
        chk("bp_second_valid", vld_s, 1);
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", vld_s, 0);
        chk("bp_drain_acc", acc_s, 12);

        // Streaming one op per cycle
        in_valid   = 1'b1;
        in_operand = 8'd1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("stream%0d_acc", k), acc_s, 13 + k);
            chk($sformatf("stream%0d_valid", k), vld_s, 1);
        end
        in_valid = 1'b0;
        step();

        // Counter saturation, then clear with an operand offered
        do_clear();
        in_valid   = 1'b1;
        in_sub     = 1'b0;
        in_operand = 8'h7F;
        step();
        for (int k = 0; k < 5; k++) step();
        in_valid = 1'b0;
        chk("cnt_sat_acc", acc_s, 8'h7F);
        chk("cnt_sat_count", cnt_s, 3);
        chk("cnt_sat_sticky", stk_s, 1);
        chk("cnt_wrap_acc", acc_w, 8'hFA);
        chk("cnt_wrap_count", cnt_w, 3);
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_operand = 8'd9;
        #1;
        chk("clr_in_ready", rdy_s, 0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_acc", acc_s, 0);
        chk("clr_valid", vld_s, 0);
        chk("clr_ovf", ovf_s, 0);
        chk("clr_sticky", stk_s, 0);
        chk("clr_count", cnt_s, 0);
        chk("clr_count_w", cnt_w, 0);
        step();
        chk("clr_dropped_acc", acc_s, 0);
        chk("clr_dropped_valid", vld_s, 0);

        // Reset while a result is held
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_operand = 8'd9;
        step();
        in_valid = 1'b0;
        chk("rsthold_valid_pre", vld_s, 1);
        chk("rsthold_acc_pre", acc_s, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rsthold_valid", vld_s, 0);
        chk("rsthold_acc", acc_s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
